// File: rtl/uart_tx_channel.sv
// UART transmit channel: write-side FIFO feeding a start/data/[parity]/stop frame serialiser.
// Define UART_TX_PARITY_EN to insert a parity bit (odd/even per Parity_Odd) after the data bits.
module uart_tx_channel #(
    parameter int unsigned CLK_DIV    = 434,
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned STOP_BITS  = 1,
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic                          CLK,
    input  logic                          RST,
    input  logic                          Write_Req_Sig,
    input  logic [DATA_BITS-1:0]          FIFO_Write_Data,
    input  logic                          Parity_Odd,
    output logic                          Full_Sig,
    output logic [$clog2(FIFO_DEPTH):0]   Level,
    output logic                          Overflow_Sig,
    output logic                          Busy_Sig,
    output logic                          TX_Done_Sig,
    output logic                          TX_Pin_Out
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam int CW = $clog2(CLK_DIV);
    localparam int BW = $clog2(DATA_BITS);

    localparam logic [CW-1:0] BaudLast = CW'(CLK_DIV - 1);
    localparam logic [BW-1:0] DataLast = BW'(DATA_BITS - 1);
    localparam logic [BW-1:0] StopLast = BW'(STOP_BITS - 1);
    localparam logic [LW-1:0] DepthLvl = LW'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
`ifdef UART_TX_PARITY_EN
        StParity,
`endif
        StStop
    } state_e;

    // FIFO storage and bookkeeping
    logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr_q, rd_ptr_q;
    logic [LW-1:0]        level_q, level_d;
    logic                 full_q, full_d;
    logic                 ovf_q;
    logic                 push, pop;

    // Serialiser state
    state_e               state_q, state_d;
    logic [CW-1:0]        baud_q, baud_d;
    logic [BW-1:0]        bit_q, bit_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 baud_end;
    logic                 tx_q, tx_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;

`ifdef UART_TX_PARITY_EN
    logic                 parity_q, parity_d;
`else
    logic                 unused_parity_odd;
    assign unused_parity_odd = Parity_Odd;
`endif

    // Full is taken from the registered level, so a pop never frees a slot the same cycle.
    assign push     = Write_Req_Sig && !full_q;
    assign pop      = (state_q == StIdle) && (level_q != '0);
    assign baud_end = (baud_q == BaudLast);

    always_comb begin
        level_d = level_q;
        if (push && !pop) begin
            level_d = level_q + 1'b1;
        end else if (pop && !push) begin
            level_d = level_q - 1'b1;
        end
        full_d = (level_d == DepthLvl);
    end

    always_ff @(posedge CLK) begin
        if (push) begin
            mem_q[wr_ptr_q] <= FIFO_Write_Data;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            full_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            level_q <= level_d;
            full_q  <= full_d;
            ovf_q   <= Write_Req_Sig && full_q;
        end
    end

    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
`ifdef UART_TX_PARITY_EN
        parity_d = parity_q;
`endif
        case (state_q)
            StIdle: begin
                if (pop) begin
                    shift_d = mem_q[rd_ptr_q];
`ifdef UART_TX_PARITY_EN
                    parity_d = (^mem_q[rd_ptr_q]) ^ Parity_Odd;
`endif
                    baud_d  = '0;
                    bit_d   = '0;
                    state_d = StStart;
                end
            end
            StStart: begin
                if (baud_end) begin
                    baud_d  = '0;
                    state_d = StData;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            StData: begin
                if (baud_end) begin
                    baud_d = '0;
                    if (bit_q == DataLast) begin
                        bit_d = '0;
`ifdef UART_TX_PARITY_EN
                        state_d = StParity;
`else
                        state_d = StStop;
`endif
                    end else begin
                        bit_d   = bit_q + 1'b1;
                        shift_d = shift_q >> 1;
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
`ifdef UART_TX_PARITY_EN
            StParity: begin
                if (baud_end) begin
                    baud_d  = '0;
                    state_d = StStop;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
`endif
            StStop: begin
                if (baud_end) begin
                    baud_d = '0;
                    if (bit_q == StopLast) begin
                        bit_d   = '0;
                        state_d = StIdle;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Outputs are decoded from next state so the registered pins line up with the FSM.
    always_comb begin
        tx_d = 1'b1;
        case (state_d)
            StStart:  tx_d = 1'b0;
            StData:   tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
            StParity: tx_d = parity_d;
`endif
            default:  tx_d = 1'b1;
        endcase
        busy_d = (state_d != StIdle);
        done_d = (state_d == StStop) && (baud_d == BaudLast) && (bit_d == StopLast);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= StIdle;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef UART_TX_PARITY_EN
            parity_q <= parity_d;
`endif
        end
    end

    assign Full_Sig     = full_q;
    assign Level        = level_q;
    assign Overflow_Sig = ovf_q;
    assign Busy_Sig     = busy_q;
    assign TX_Done_Sig  = done_q;
    assign TX_Pin_Out   = tx_q;

endmodule

// File: tb/tb_uart_tx_channel.sv
// Scoreboard bench for uart_tx_channel: a line monitor decodes every frame cycle by cycle
// and compares it against words queued when the bench issues writes.
module tb_uart_tx_channel;

    localparam int DIV   = 4;
    localparam int DB    = 8;
    localparam int SB    = 1;
    localparam int DEPTH = 4;
`ifdef UART_TX_PARITY_EN
    localparam int P = 1;
`else
    localparam int P = 0;
`endif
    localparam int NB     = 1 + DB + P + SB;
    localparam int FRAME  = NB * DIV;
    localparam int LW     = $clog2(DEPTH) + 1;
    localparam int DIV2   = 3;
    localparam int DB2    = 5;
    localparam int SB2    = 2;
    localparam int NB2    = 1 + DB2 + P + SB2;
    localparam int FRAME2 = NB2 * DIV2;

    typedef struct packed {
        logic          odd;
        logic [DB-1:0] data;
    } item_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          wr = 1'b0;
    logic [DB-1:0] wdata = '0;
    logic          par_odd = 1'b0;
    logic          full, ovf, busy, done, tx;
    logic [LW-1:0] level;

    logic           wr2 = 1'b0;
    logic [DB2-1:0] wdata2 = '0;
    logic           par_odd2 = 1'b1;
    logic           full2, ovf2, busy2, done2, tx2;
    logic [LW-1:0]  level2;

    item_t exp_q[$];
    int    starts[$];
    int    checks, failures, stray_done, cyc;
    bit    mon_busy;

    uart_tx_channel #(
        .CLK_DIV(DIV), .DATA_BITS(DB), .STOP_BITS(SB), .FIFO_DEPTH(DEPTH)
    ) dut (
        .CLK(clk), .RST(rst), .Write_Req_Sig(wr), .FIFO_Write_Data(wdata),
        .Parity_Odd(par_odd), .Full_Sig(full), .Level(level), .Overflow_Sig(ovf),
        .Busy_Sig(busy), .TX_Done_Sig(done), .TX_Pin_Out(tx)
    );

    uart_tx_channel #(
        .CLK_DIV(DIV2), .DATA_BITS(DB2), .STOP_BITS(SB2), .FIFO_DEPTH(DEPTH)
    ) dut2 (
        .CLK(clk), .RST(rst), .Write_Req_Sig(wr2), .FIFO_Write_Data(wdata2),
        .Parity_Odd(par_odd2), .Full_Sig(full2), .Level(level2), .Overflow_Sig(ovf2),
        .Busy_Sig(busy2), .TX_Done_Sig(done2), .TX_Pin_Out(tx2)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Frame monitor: checks line, Busy_Sig and TX_Done_Sig on every cycle of each frame.
    initial begin : monitor
        logic          prev;
        item_t         it;
        logic [NB-1:0] want, got;
        bit            bad_line, bad_busy, bad_done, aborted;
        prev = 1'b1;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev = 1'b1;
            end else if (prev === 1'b1 && tx === 1'b0) begin
                mon_busy = 1'b1;
                starts.push_back(cyc);
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_frame: start bit at cycle %0d, required none", cyc);
                    prev = 1'b0;
                end else begin
                    it = exp_q.pop_front();
                    want = '1;
                    want[0] = 1'b0;
                    for (int i = 0; i < DB; i++) want[1+i] = it.data[i];
                    if (P == 1) want[1+DB] = (^it.data) ^ it.odd;
                    got = '1;
                    bad_line = 0; bad_busy = 0; bad_done = 0; aborted = 0;
                    for (int c = 0; c < FRAME; c++) begin
                        if (c > 0) @(negedge clk);
                        if (rst) begin
                            aborted = 1;
                            break;
                        end
                        if (c % DIV == DIV / 2) got[c/DIV] = tx;
                        if (tx !== want[c/DIV]) bad_line = 1;
                        if (busy !== 1'b1) bad_busy = 1;
                        if (done !== (c == FRAME - 1)) bad_done = 1;
                    end
                    if (!aborted) begin
                        checks += 3;
                        if (bad_line) begin
                            failures++;
                            $display("FAIL frame_bits: got %b required %b (bit0 first on right)",
                                     got, want);
                        end
                        if (bad_busy) begin
                            failures++;
                            $display("FAIL frame_busy: Busy_Sig low during frame data=%h, required high",
                                     it.data);
                        end
                        if (bad_done) begin
                            failures++;
                            $display("FAIL frame_done: TX_Done_Sig misplaced in frame data=%h, required only last cycle",
                                     it.data);
                        end
                    end
                    prev = aborted ? 1'b1 : tx;
                end
                mon_busy = 1'b0;
            end else begin
                if (done === 1'b1) stray_done++;
                prev = tx;
            end
        end
    end

    task automatic queue_write(input logic [DB-1:0] d, input logic odd, input bit accept);
        item_t it;
        @(posedge clk); #1;
        wr = 1'b1;
        wdata = d;
        if (accept) begin
            it.odd = odd;
            it.data = d;
            exp_q.push_back(it);
        end
    endtask

    task automatic wait_drain(input int budget, output int pending);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || mon_busy) && n < budget) begin
            @(negedge clk);
            n++;
        end
        pending = exp_q.size() + (mon_busy ? 1 : 0);
    endtask

    task automatic test_reset;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks += 6;
        if (tx !== 1'b1)   begin failures++; $display("FAIL reset_tx: got %b required 1", tx); end
        if (full !== 1'b0) begin failures++; $display("FAIL reset_full: got %b required 0", full); end
        if (level !== '0)  begin failures++; $display("FAIL reset_level: got %0d required 0", level); end
        if (ovf !== 1'b0)  begin failures++; $display("FAIL reset_ovf: got %b required 0", ovf); end
        if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b required 0", busy); end
        if (done !== 1'b0) begin failures++; $display("FAIL reset_done: got %b required 0", done); end
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_single_frame;
        int c0, pending, s0;
        starts.delete();
        queue_write(8'h55, 1'b0, 1'b1);
        c0 = cyc;
        @(posedge clk); #1;
        wr = 1'b0;
        @(negedge clk);
        checks += 2;
        if (level !== LW'(1)) begin failures++; $display("FAIL single_level: got %0d required 1", level); end
        if (busy !== 1'b0)    begin failures++; $display("FAIL single_busy_pop: got %b required 0", busy); end
        @(negedge clk);
        checks += 2;
        if (busy !== 1'b1) begin failures++; $display("FAIL single_busy_start: got %b required 1", busy); end
        if (level !== '0)  begin failures++; $display("FAIL single_level_after_pop: got %0d required 0", level); end
        wait_drain(FRAME + 20, pending);
        checks++;
        if (pending !== 0) begin failures++; $display("FAIL single_drain: %0d pending, required 0", pending); end
        s0 = (starts.size() > 0) ? starts[0] : -1;
        checks++;
        if (s0 !== c0 + 2) begin failures++; $display("FAIL single_start_cycle: got %0d required %0d", s0, c0 + 2); end
    endtask

    task automatic test_parity_back_to_back;
        int c0, pending, s0, gap;
        starts.delete();
        par_odd = 1'b0;
        queue_write(8'hA3, 1'b0, 1'b1);
        c0 = cyc;
        queue_write(8'hA3, 1'b1, 1'b1);
        @(posedge clk); #1;
        wr = 1'b0;
        par_odd = 1'b1;
        wait_drain(3 * FRAME + 20, pending);
        checks++;
        if (pending !== 0) begin failures++; $display("FAIL b2b_drain: %0d pending, required 0", pending); end
        s0  = (starts.size() > 0) ? starts[0] : -1;
        gap = (starts.size() > 1) ? starts[1] - starts[0] : -1;
        checks += 2;
        if (s0 !== c0 + 2) begin failures++; $display("FAIL b2b_first_start: got %0d required %0d", s0, c0 + 2); end
        if (gap !== FRAME + 1) begin failures++; $display("FAIL b2b_spacing: got %0d required %0d", gap, FRAME + 1); end
        par_odd = 1'b0;
    endtask

    task automatic test_overflow;
        int c0, peak, ovf_n, ovf_at, pending;
        starts.delete();
        peak = 0; ovf_n = 0; ovf_at = -1; c0 = 0;
        for (int i = 0; i < 12; i++) begin
            if (i < 6) begin
                queue_write(DB'(8'h31 + i), 1'b0, i < 5);
                if (i == 0) c0 = cyc;
            end else begin
                @(posedge clk); #1;
                wr = 1'b0;
            end
            @(negedge clk);
            if (int'(level) > peak) peak = int'(level);
            if (ovf === 1'b1) begin ovf_n++; ovf_at = cyc - c0; end
            if (i == 4) begin
                checks++;
                if (full !== 1'b0) begin failures++; $display("FAIL ovf_full_early: got %b required 0", full); end
            end
            if (i == 5) begin
                checks++;
                if (full !== 1'b1) begin failures++; $display("FAIL ovf_full: got %b required 1", full); end
            end
        end
        checks += 3;
        if (peak !== DEPTH) begin failures++; $display("FAIL ovf_peak_level: got %0d required %0d", peak, DEPTH); end
        if (ovf_n !== 1) begin failures++; $display("FAIL ovf_pulse_count: got %0d required 1", ovf_n); end
        if (ovf_at !== 6) begin failures++; $display("FAIL ovf_pulse_cycle: got c+%0d required c+6", ovf_at); end
        wait_drain(6 * FRAME + 40, pending);
        checks++;
        if (pending !== 0) begin failures++; $display("FAIL ovf_drain: %0d pending, required 0", pending); end
    endtask

    task automatic test_five_bit_two_stop;
        logic [NB2-1:0] want;
        logic [DB2-1:0] d;
        logic           exp_tx, exp_done, exp_busy;
        int             c0, bad;
        d = 5'h1F;
        want = '1;
        want[0] = 1'b0;
        for (int i = 0; i < DB2; i++) want[1+i] = d[i];
        if (P == 1) want[1+DB2] = (^d) ^ par_odd2;
        @(posedge clk); #1;
        wr2 = 1'b1;
        wdata2 = d;
        c0 = cyc;
        @(posedge clk); #1;
        wr2 = 1'b0;
        bad = 0;
        for (int cy = c0 + 1; cy <= c0 + 2 + FRAME2; cy++) begin
            @(negedge clk);
            exp_busy = (cy >= c0 + 2) && (cy < c0 + 2 + FRAME2);
            exp_tx   = exp_busy ? want[(cy - c0 - 2) / DIV2] : 1'b1;
            exp_done = (cy == c0 + 1 + FRAME2);
            checks += 3;
            if (tx2 !== exp_tx) begin
                failures++;
                $display("FAIL b5s2_line c+%0d: got %b required %b", cy - c0, tx2, exp_tx);
            end
            if (busy2 !== exp_busy) begin
                failures++;
                $display("FAIL b5s2_busy c+%0d: got %b required %b", cy - c0, busy2, exp_busy);
            end
            if (done2 !== exp_done) begin
                failures++;
                $display("FAIL b5s2_done c+%0d: got %b required %b", cy - c0, done2, exp_done);
            end
        end
    endtask

    task automatic test_reset_mid_frame;
        int c0, target, stray0, nstart;
        starts.delete();
        stray0 = stray_done;
        queue_write(8'h11, 1'b0, 1'b1);
        c0 = cyc;
        queue_write(8'h22, 1'b0, 1'b1);
        queue_write(8'h33, 1'b0, 1'b1);
        queue_write(8'h44, 1'b0, 1'b1);
        @(posedge clk); #1;
        wr = 1'b0;
        target = c0 + 2 + DIV + 6;
        while (cyc < target) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        exp_q.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        checks += 4;
        if (tx !== 1'b1)   begin failures++; $display("FAIL midrst_tx: got %b required 1", tx); end
        if (level !== '0)  begin failures++; $display("FAIL midrst_level: got %0d required 0", level); end
        if (busy !== 1'b0) begin failures++; $display("FAIL midrst_busy: got %b required 0", busy); end
        if (done !== 1'b0) begin failures++; $display("FAIL midrst_done: got %b required 0", done); end
        repeat (3 * FRAME) @(negedge clk);
        nstart = starts.size();
        checks += 3;
        if (nstart !== 1) begin failures++; $display("FAIL midrst_frames: got %0d starts required 1", nstart); end
        if (stray_done !== stray0) begin
            failures++;
            $display("FAIL midrst_stray_done: got %0d pulses required %0d", stray_done, stray0);
        end
        if (tx !== 1'b1) begin failures++; $display("FAIL midrst_line_idle: got %b required 1", tx); end
    endtask

    task automatic test_streaming;
        int peak, ovf_n, pending;
        peak = 0; ovf_n = 0;
        for (int w = 0; w < 64; w++) begin
            queue_write(DB'($urandom), 1'b0, 1'b1);
            @(negedge clk);
            if (int'(level) > peak) peak = int'(level);
            if (ovf === 1'b1) ovf_n++;
            @(posedge clk); #1;
            wr = 1'b0;
            repeat (FRAME + 3) begin
                @(negedge clk);
                if (int'(level) > peak) peak = int'(level);
                if (ovf === 1'b1) ovf_n++;
            end
        end
        wait_drain(2 * FRAME + 20, pending);
        checks += 4;
        if (pending !== 0) begin failures++; $display("FAIL stream_drain: %0d pending, required 0", pending); end
        if (peak !== 1) begin failures++; $display("FAIL stream_peak_level: got %0d required 1", peak); end
        if (ovf_n !== 0) begin failures++; $display("FAIL stream_overflow: got %0d pulses required 0", ovf_n); end
        if (stray_done !== 0) begin
            failures++;
            $display("FAIL stray_done: got %0d pulses outside frames required 0", stray_done);
        end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_parity_back_to_back();
        test_overflow();
        test_five_bit_two_stop();
        test_reset_mid_frame();
        test_streaming();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
